// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with busy scoreboard; optional REGFILE_BYPASS_EN
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*$clog2(NUM_REGS)-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*$clog2(NUM_REGS)-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       alloc_en,
  input  logic [$clog2(NUM_REGS)-1:0] alloc_addr,
  output logic [NUM_REGS-1:0]        busy_vec
);

  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // Scoreboard next state: writes retire producers, an alloc wins over a same-cycle write
  always_comb begin
    busy_next = busy;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        busy_next[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (alloc_en) begin
      busy_next[alloc_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Register array: later ports overwrite earlier ones, so the highest index wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign busy_vec = busy;

  // Combinational read ports; register 0 is forced to zero and never busy
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i*DATA_W +: DATA_W] = regs[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
          rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
        end
      end
      rd_busy[i] = busy_next[rd_addr[i*AW +: AW]];
`else
      rd_busy[i] = busy[rd_addr[i*AW +: AW]];
`endif
      if (rd_addr[i*AW +: AW] == '0) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
        rd_busy[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (two write ports)
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int RD = 2;
  localparam int WR = 2;
  localparam int AW = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic [RD*AW-1:0]   rd_addr;
  logic [RD*DW-1:0]   rd_data;
  logic [RD-1:0]      rd_busy;
  logic [WR-1:0]      wr_en;
  logic [WR*AW-1:0]   wr_addr;
  logic [WR*DW-1:0]   wr_data;
  logic               alloc_en;
  logic [AW-1:0]      alloc_addr;
  logic [NR-1:0]      busy_vec;

  int n_vec = 0;
  int n_bad = 0;

  // Architectural model: value and pending-producer flag per register
  logic [DW-1:0] mdl_val [NR];
  bit            mdl_busy [NR];

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(RD), .NUM_WR(WR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  // Value a read of register a must return this cycle
  function automatic logic [DW-1:0] exp_data(input int a);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = mdl_val[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < WR; j++)
      if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) v = wr_data[j*DW +: DW];
`endif
    return v;
  endfunction

  // Busy flag a read of register a must report this cycle
  function automatic bit exp_busy(input int a);
    bit b;
    if (a == 0) return 1'b0;
    b = mdl_busy[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < WR; j++)
      if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) b = 1'b0;
    if (alloc_en && int'(alloc_addr) == a) b = 1'b1;
`endif
    return b;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge, from the inputs presented that cycle
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        mdl_val[r] = '0;
        mdl_busy[r] = 1'b0;
      end
    end else begin
      for (int j = 0; j < WR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != 0) begin
          mdl_val[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
          mdl_busy[wr_addr[j*AW +: AW]] = 1'b0;
        end
      end
      if (alloc_en && alloc_addr != 0) mdl_busy[alloc_addr] = 1'b1;
    end
  end

  // Per-cycle comparison of every output against the model, away from the active edge
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      logic [NR-1:0] bv;
      for (int r = 0; r < NR; r++) bv[r] = mdl_busy[r];
      chk("busy_vec", busy_vec, bv);
      for (int i = 0; i < RD; i++) begin
        chk($sformatf("rd_data[%0d]", i), rd_data[i*DW +: DW], exp_data(int'(rd_addr[i*AW +: AW])));
        chk($sformatf("rd_busy[%0d]", i), {31'b0, rd_busy[i]}, {31'b0, exp_busy(int'(rd_addr[i*AW +: AW]))});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0;
    alloc_en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    alloc_en = 1'b0;
    alloc_addr = '0;
    step();
    step();
    idle();

    // Reset state across all registers
    for (int r = 0; r < NR; r++) begin
      set_rd(0, r);
      set_rd(1, NR - 1 - r);
      #1;
      chk("reset_rd0", rd_data[0 +: DW], 32'h0);
      chk("reset_rd1", rd_data[DW +: DW], 32'h0);
      step();
    end
    chk("reset_busy_vec", busy_vec, 32'h0);

    // Plain write, then read back; write to register 0 is dropped
    set_wr(0, 5, 32'hDEADBEEF);
    set_rd(0, 5);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("wr5_same_cycle", rd_data[0 +: DW], 32'hDEADBEEF);
`else
    chk("wr5_same_cycle", rd_data[0 +: DW], 32'h0);
`endif
    step();
    idle();
    #1;
    chk("wr5_next", rd_data[0 +: DW], 32'hDEADBEEF);
    set_wr(0, 0, 32'h1234);
    set_rd(1, 0);
    step();
    idle();
    #1;
    chk("wr0_ignored", rd_data[DW +: DW], 32'h0);

    // Two ports hit register 7: higher port index wins
    set_wr(0, 7, 32'h11);
    set_wr(1, 7, 32'h22);
    step();
    idle();
    set_rd(0, 7);
    #1;
    chk("collision_r7", rd_data[0 +: DW], 32'h22);

    // Scoreboard: alloc, retire, alloc beats write
    alloc_en = 1'b1;
    alloc_addr = 5'd9;
    step();
    idle();
    set_rd(1, 9);
    #1;
    chk("alloc9_busy_vec", {31'b0, busy_vec[9]}, 32'h1);
    chk("alloc9_rd_busy", {31'b0, rd_busy[1]}, 32'h1);
    set_wr(1, 9, 32'hA5);
    step();
    idle();
    #1;
    chk("wr9_busy_clear", {31'b0, busy_vec[9]}, 32'h0);
    chk("wr9_data", rd_data[DW +: DW], 32'hA5);
    alloc_en = 1'b1;
    alloc_addr = 5'd9;
    set_wr(0, 9, 32'h5A);
    step();
    idle();
    #1;
    chk("alloc_wr9_busy", {31'b0, busy_vec[9]}, 32'h1);
    chk("alloc_wr9_data", rd_data[DW +: DW], 32'h5A);
    alloc_en = 1'b1;
    alloc_addr = 5'd0;
    step();
    idle();
    #1;
    chk("alloc0_ignored", busy_vec, 32'h0000_0200);

    // Same-cycle write and read of register 3
    set_wr(0, 3, 32'h55);
    set_rd(0, 3);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("r3_same_cycle", rd_data[0 +: DW], 32'h55);
`else
    chk("r3_same_cycle", rd_data[0 +: DW], 32'h0);
`endif
    step();
    idle();
    #1;
    chk("r3_next", rd_data[0 +: DW], 32'h55);

    // Reset wins over a same-cycle write and alloc
    rst = 1'b1;
    set_wr(0, 4, 32'hFF);
    alloc_en = 1'b1;
    alloc_addr = 5'd4;
    step();
    idle();
    set_rd(0, 4);
    #1;
    chk("rst_r4_data", rd_data[0 +: DW], 32'h0);
    chk("rst_r4_busy", {31'b0, busy_vec[4]}, 32'h0);

    // Mixed traffic, checked cycle by cycle against the model
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < WR; j++) begin
        wr_en[j] = ($urandom_range(0, 1) == 1);
        wr_addr[j*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[j*DW +: DW] = $urandom;
      end
      alloc_en = ($urandom_range(0, 2) == 0);
      alloc_addr = AW'($urandom_range(0, 7));
      set_rd(0, $urandom_range(0, 7));
      set_rd(1, $urandom_range(0, 7));
      step();
    end
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
